// File: rtl/metaball_pkg.sv
// metaball_pkg
// Shared types and helpers for the metaball scheduler and the metaball
// evaluators it drives.
//   state_t    : scheduler FSM states
//   FIX_INT_W  : integer bits of the 16.16 fixed-point coordinate/velocity format
//   FIX_FRAC_W : fractional bits of the 16.16 fixed-point format
//   MAX_BALLS  : largest supported ball bank (width of the popcount input)
//   popcount() : number of set bits in a ball vector
package metaball_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    EMIT,
    MOVE
  } state_t;

  localparam int FIX_INT_W  = 16;
  localparam int FIX_FRAC_W = 16;
  localparam int MAX_BALLS  = 16;

  // Callers zero-extend their N_BALLS-wide vector to MAX_BALLS bits.
  function automatic logic [4:0] popcount(input logic [MAX_BALLS-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < MAX_BALLS; i++) begin
      c = c + 5'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// raster_counter
// Raster-scan x/y position plus the matching linear framebuffer address.
// The address is a running counter kept in step with x/y, so no y*H_RES
// multiply is needed.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   adv      : step to the next pixel (ignored on the last pixel)
//   clr      : return to pixel 0 (frame boundary)
//   x, y     : current pixel coordinate
//   addr     : y*H_RES + x
//   last     : current pixel is (H_RES-1, V_RES-1)
module raster_counter #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int COORD_W = 16,
  parameter int ADDR_W  = $clog2(H_RES*V_RES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               adv,
  input  logic               clr,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  addr,
  output logic               last
);

  assign last = (x == COORD_W'(H_RES-1)) && (y == COORD_W'(V_RES-1));

  // Holding on the last pixel keeps addr within the frame; only clr wraps it.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (adv && !last) begin
      addr <= addr + 1'b1;
      if (x == COORD_W'(H_RES-1)) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/metaball_sched.sv
// metaball_sched
// Frame scheduler for a bank of N_BALLS metaball evaluators. Each pixel
// coordinate is strobed to every ball, the per-ball hits are collected and
// reduced to one lit/unlit bit (at least MIN_HITS hits), and the pixel is
// handed to the framebuffer writer over valid/ready. After the last pixel
// of a frame, mb_mov_en/frame_done pulse once so the balls animate.
// Optional build macro METABALL_SCHED_TIMEOUT_EN adds a WAIT watchdog of
// TIMEOUT cycles and the sticky timeout_flag output.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   run                      : keep generating frames while high
//   mb_px_stb, mb_p_x/mb_p_y : coordinate strobe to all balls
//   mb_mov_en                : per-frame animation step pulse
//   mb_vld, mb_out           : per-ball result valid and inside-field bit
//   pix_valid/ready/data/addr: pixel output handshake
//   frame_done               : pulse coincident with mb_mov_en
//   busy                     : FSM not in IDLE
//   timeout_flag             : (optional) a pixel was emitted on timeout
module metaball_sched
  import metaball_pkg::*;
#(
  parameter int N_BALLS  = 4,
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int COORD_W  = FIX_INT_W,
  parameter int MIN_HITS = 1,
  parameter int TIMEOUT  = 255,
  localparam int ADDR_W  = $clog2(H_RES*V_RES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               mb_px_stb,
  output logic [COORD_W-1:0] mb_p_x,
  output logic [COORD_W-1:0] mb_p_y,
  output logic               mb_mov_en,
  input  logic [N_BALLS-1:0] mb_vld,
  input  logic [N_BALLS-1:0] mb_out,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               pix_data,
  output logic [ADDR_W-1:0]  pix_addr,
`ifdef METABALL_SCHED_TIMEOUT_EN
  output logic               timeout_flag,
`endif
  output logic               frame_done,
  output logic               busy
);

  state_t             state;
  logic [N_BALLS-1:0] done;
  logic [N_BALLS-1:0] hit;
  logic [N_BALLS-1:0] done_nxt;
  logic [N_BALLS-1:0] hit_nxt;
  logic               all_done;
  logic               go_emit;
  logic               handshake;
  logic               last_pix;
  logic               lit;

  assign handshake = (state == EMIT) && pix_ready;

  raster_counter #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .COORD_W(COORD_W),
    .ADDR_W (ADDR_W)
  ) u_raster (
    .clk (clk),
    .rst (rst),
    .adv (handshake),
    .clr (state == MOVE),
    .x   (mb_p_x),
    .y   (mb_p_y),
    .addr(pix_addr),
    .last(last_pix)
  );

  // First capture per ball wins: later vld pulses for a ball already done
  // leave its hit bit untouched.
  always_comb begin
    done_nxt = done | mb_vld;
    hit_nxt  = hit | (mb_vld & ~done & mb_out);
  end

  assign all_done = &done_nxt;
  assign lit      = (32'(popcount(MAX_BALLS'(hit_nxt))) >= MIN_HITS);

`ifdef METABALL_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT+1);
  logic [TO_W-1:0] wait_cnt;
  // Timeout fires on the TIMEOUT-th WAIT cycle; missing balls count as unlit.
  assign go_emit = all_done || (wait_cnt == TO_W'(TIMEOUT-1));
`else
  assign go_emit = all_done;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      done       <= '0;
      hit        <= '0;
      mb_px_stb  <= 1'b0;
      mb_mov_en  <= 1'b0;
      frame_done <= 1'b0;
      pix_valid  <= 1'b0;
      pix_data   <= 1'b0;
      busy       <= 1'b0;
`ifdef METABALL_SCHED_TIMEOUT_EN
      wait_cnt     <= '0;
      timeout_flag <= 1'b0;
`endif
    end else begin
      // Strobe and frame pulses are single-cycle by default.
      mb_px_stb  <= 1'b0;
      mb_mov_en  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state     <= ISSUE;
            mb_px_stb <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ISSUE: begin
          // mb_vld seen in the strobe cycle belongs to no pixel; not captured.
          done  <= '0;
          hit   <= '0;
          state <= WAIT;
`ifdef METABALL_SCHED_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          done <= done_nxt;
          hit  <= hit_nxt;
`ifdef METABALL_SCHED_TIMEOUT_EN
          wait_cnt <= wait_cnt + 1'b1;
          if (go_emit && !all_done) begin
            timeout_flag <= 1'b1;
          end
`endif
          if (go_emit) begin
            state     <= EMIT;
            pix_valid <= 1'b1;
            pix_data  <= lit;
          end
        end
        EMIT: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            if (last_pix) begin
              state      <= MOVE;
              mb_mov_en  <= 1'b1;
              frame_done <= 1'b1;
            end else begin
              state     <= ISSUE;
              mb_px_stb <= 1'b1;
            end
          end
        end
        MOVE: begin
          // run is only honoured here, so a started frame always completes.
          if (run) begin
            state     <= ISSUE;
            mb_px_stb <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
